vector_shift_engine: RTL and testbench



---
 rtl/vector_shift_engine_pkg.sv | 20 ++
 rtl/vector_shift_engine_shift_lane.sv | 57 +++++
 rtl/vector_shift_engine.sv | 131 +++++++++++++
 tb/tb_vector_shift_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_shift_engine_pkg.sv
// Shared constants, shift-mode encodings, FSM state codes and vector type for the
// vector shift engine.
package vector_shift_engine_pkg;

  localparam int unsigned MAX_NEURONS = 16;
  localparam int unsigned DATA_W      = 32;

  localparam logic [1:0] SHM_LSR      = 2'b00;
  localparam logic [1:0] SHM_ASR      = 2'b01;
  localparam logic [1:0] SHM_LSL_SAT  = 2'b10;
  localparam logic [1:0] SHM_LSL_WRAP = 2'b11;

  typedef logic [1:0] vse_state_t;
  localparam vse_state_t ST_IDLE = 2'd0;
  localparam vse_state_t ST_PROC = 2'd1;
  localparam vse_state_t ST_DONE = 2'd2;

  typedef logic [MAX_NEURONS-1:0][DATA_W-1:0] vec_t;

endpackage

// File: rtl/vector_shift_engine_shift_lane.sv
// Combinational single-element shifter: logical/arithmetic right with optional
// round-half-up, left saturating (with overflow flag) and left wrapping.
module vector_shift_engine_shift_lane #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] s,
  input  logic [1:0]         mode,
  input  logic               rnd,
  output logic [WIDTH-1:0]   y,
  output logic               ovf
);
  import vector_shift_engine_pkg::*;

  logic               big;
  logic               rbit;
  logic               fits;
  logic [SHAMT_W-1:0] sm1;
  logic [WIDTH-1:0]   lsr;
  logic [WIDTH-1:0]   asr;
  logic [WIDTH-1:0]   lsl;
  logic [WIDTH-1:0]   back;
  logic [WIDTH-1:0]   rnd_src;

  always_comb begin
    big     = 32'(s) >= WIDTH;
    lsr     = x >> s;
    asr     = $signed(x) >>> s;
    lsl     = x << s;
    back    = $signed(lsl) >>> s;
    // Exact left shift iff shifting back recovers the original value.
    fits    = !big && (back == x);
    sm1     = s - SHAMT_W'(1);
    rnd_src = x >> sm1;
    rbit    = rnd && (s != '0) && !big && rnd_src[0];

    y   = '0;
    ovf = 1'b0;
    unique case (mode)
      SHM_LSR: y = lsr + WIDTH'(rbit);
      SHM_ASR: y = asr + WIDTH'(rbit);
      SHM_LSL_SAT: begin
        if (x == '0) begin
          y = '0;
        end else if (fits) begin
          y = lsl;
        end else begin
          y   = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          ovf = 1'b1;
        end
      end
      SHM_LSL_WRAP: y = lsl;
    endcase
  end

endmodule

// File: rtl/vector_shift_engine.sv
// Handshaked vector shifter: captures a vector, shifts LANES elements per cycle
// into a result register, then holds the result until the consumer takes it.
module vector_shift_engine #(
  parameter int unsigned N_ELEM  = vector_shift_engine_pkg::MAX_NEURONS,
  parameter int unsigned DATA_W  = vector_shift_engine_pkg::DATA_W,
  parameter int unsigned LANES   = 4,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ELEM*DATA_W-1:0] in_vector,
  input  logic [SHAMT_W-1:0]       in_shamt,
  input  logic [1:0]               in_mode,
  input  logic                     in_round,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_ELEM*DATA_W-1:0] out_vector,
  output logic                     out_ovf
);
  import vector_shift_engine_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_ELEM + LANES + 1);
  localparam int unsigned EW    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  vse_state_t                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N_ELEM-1:0][DATA_W-1:0] src_q, res_q, res_d;
  logic [SHAMT_W-1:0]            shamt_q;
  logic [1:0]                    mode_q;
  logic                          round_q;
  logic                          ovf_q, ovf_d;
  logic                          accept;

  logic [LANES-1:0][31:0]        lane_pos;
  logic [LANES-1:0][EW-1:0]      lane_idx;
  logic [LANES-1:0]              lane_en;
  logic [LANES-1:0][DATA_W-1:0]  lane_x, lane_y;
  logic [LANES-1:0]              lane_ovf;

  // Lanes past the last element are disabled: they read zero and write nothing.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_pos[l] = 32'(idx_q) + 32'(l);
      lane_en[l]  = lane_pos[l] < N_ELEM;
      lane_idx[l] = lane_pos[l][EW-1:0];
      lane_x[l]   = lane_en[l] ? src_q[lane_idx[l]] : '0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_shift_engine_shift_lane #(
      .WIDTH   (DATA_W),
      .SHAMT_W (SHAMT_W)
    ) u_lane (
      .x    (lane_x[g]),
      .s    (shamt_q),
      .mode (mode_q),
      .rnd  (round_q),
      .y    (lane_y[g]),
      .ovf  (lane_ovf[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        // The index running past the end retires the vector on the next edge.
        if (32'(idx_q) >= N_ELEM) begin
          state_d = ST_DONE;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) begin
              res_d[lane_idx[l]] = lane_y[l];
              ovf_d              = ovf_d | lane_ovf[l];
            end
          end
          idx_d = idx_q + IDX_W'(LANES);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
      shamt_q <= '0;
      mode_q  <= SHM_LSR;
      round_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      if (accept) begin
        src_q   <= in_vector;
        shamt_q <= in_shamt;
        mode_q  <= in_mode;
        round_q <= in_round;
      end
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_vector = res_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_vector_shift_engine.sv
// Directed bench for vector_shift_engine: default, 10-element and full-width lane configs.
module tb_vector_shift_engine;
  import vector_shift_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, in_round;
  vec_t        in_vector, out_vector;
  logic [5:0]  in_shamt;
  logic [1:0]  in_mode;

  logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_ovf;
  logic [9:0][31:0] v1_in, v1_out;
  logic        v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_ovf;
  vec_t        v2_in, v2_out;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  vector_shift_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vector(in_vector), .in_shamt(in_shamt), .in_mode(in_mode), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector), .out_ovf(out_ovf)
  );

  vector_shift_engine #(.N_ELEM(10), .LANES(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .in_vector(v1_in), .in_shamt(in_shamt), .in_mode(in_mode), .in_round(in_round),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_vector(v1_out), .out_ovf(v1_ovf)
  );

  vector_shift_engine #(.N_ELEM(16), .LANES(16)) dutw (
    .clk(clk), .rst_n(rst_n), .in_valid(v2_in_valid), .in_ready(v2_in_ready),
    .in_vector(v2_in), .in_shamt(in_shamt), .in_mode(in_mode), .in_round(in_round),
    .out_valid(v2_out_valid), .out_ready(v2_out_ready), .out_vector(v2_out), .out_ovf(v2_ovf)
  );

  // Counts negedges after the accept edge until out_valid; -1 on timeout.
  task automatic wait0(output int lat);
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the engine idle.
  task automatic send0(input vec_t v, input logic [5:0] s, input logic [1:0] m, input logic r,
                       output int lat);
    in_vector = v; in_shamt = s; in_mode = m; in_round = r; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait0(lat);
  endtask

  task automatic drain0();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_vector !== '0) begin miscompares++;
      $display("FAIL reset_out_vector: got %h want 0", out_vector); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++;
      $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_asr();
    vec_t v, e;
    int   lat;
    v = '0; e = '0;
    v[0] = -32'sd8;        e[0] = -32'sd2;
    v[1] = 32'd7;          e[1] = 32'd1;
    v[2] = 32'h7FFF_FFFF;  e[2] = 32'h1FFF_FFFF;
    v[3] = 32'd1;          e[3] = 32'd0;
    for (int i = 4; i < 16; i++) begin
      v[i] = 32'(-(i * 4));
      e[i] = 32'(-i);
    end
    send0(v, 6'd2, SHM_ASR, 1'b0, lat);
    vectors++; if (lat !== 5) begin miscompares++;
      $display("FAIL asr_latency: got %0d want 5", lat); end
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL asr_data: got %h want %h", out_vector, e); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++;
      $display("FAIL asr_ovf: got %b want 0", out_ovf); end
    drain0();
  endtask

  task automatic test_lsr_round();
    vec_t v, e;
    int   lat;
    v = '0;
    v[0] = 32'd3; v[1] = 32'd5; v[2] = 32'hFFFF_FFFF;
    e = '0; e[0] = 32'd2; e[1] = 32'd3; e[2] = 32'h8000_0000;
    send0(v, 6'd1, SHM_LSR, 1'b1, lat);
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL lsr_round_data: got %h want %h", out_vector, e); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++;
      $display("FAIL lsr_round_ovf: got %b want 0", out_ovf); end
    drain0();
    send0(v, 6'd40, SHM_LSR, 1'b1, lat);
    vectors++; if (out_vector !== '0) begin miscompares++;
      $display("FAIL lsr_big_shift: got %h want 0", out_vector); end
    drain0();
    // Arithmetic shift past the width leaves only sign bits; rounding is inert.
    e = '0; e[2] = 32'hFFFF_FFFF;
    send0(v, 6'd40, SHM_ASR, 1'b1, lat);
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL asr_big_shift: got %h want %h", out_vector, e); end
    drain0();
  endtask

  task automatic test_lsl();
    vec_t v, e;
    int   lat;
    v = '0;
    v[0] = 32'h0100_0000; v[1] = 32'h0800_0000; v[2] = 32'hF7FF_FFFF; v[3] = 32'd0;
    e = '0;
    e[0] = 32'h1000_0000; e[1] = 32'h7FFF_FFFF; e[2] = 32'h8000_0000;
    send0(v, 6'd4, SHM_LSL_SAT, 1'b0, lat);
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL lsl_sat_data: got %h want %h", out_vector, e); end
    vectors++; if (out_ovf !== 1'b1) begin miscompares++;
      $display("FAIL lsl_sat_ovf: got %b want 1", out_ovf); end
    drain0();
    e = '0;
    e[0] = 32'h1000_0000; e[1] = 32'h8000_0000; e[2] = 32'h7FFF_FFF0;
    send0(v, 6'd4, SHM_LSL_WRAP, 1'b0, lat);
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL lsl_wrap_data: got %h want %h", out_vector, e); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++;
      $display("FAIL lsl_wrap_ovf: got %b want 0", out_ovf); end
    drain0();
  endtask

  task automatic test_back_to_back();
    vec_t a, ea, b, eb;
    int   lat;
    for (int i = 0; i < 16; i++) begin
      a[i]  = 32'(i + 1);
      ea[i] = 32'(2 * (i + 1));
      b[i]  = 32'(32'h1000 * (i + 1));
      eb[i] = 32'(32'h100 * (i + 1));
    end
    b[0] = 32'hF000_0000; eb[0] = 32'h0F00_0000;
    send0(a, 6'd1, SHM_LSL_WRAP, 1'b0, lat);
    vectors++; if (out_vector !== ea) begin miscompares++;
      $display("FAIL b2b_first_data: got %h want %h", out_vector, ea); end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < 16; j++) in_vector[j] = $urandom;
      in_shamt = 6'($urandom_range(0, 63));
      in_mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vector !== ea) begin miscompares++;
        $display("FAIL b2b_hold[%0d]: got rdy=%b vld=%b vec=%h want rdy=0 vld=1 vec=%h",
                 c, in_ready, out_valid, out_vector, ea);
      end
    end
    in_vector = b; in_shamt = 6'd4; in_mode = SHM_LSR; in_round = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++;
      $display("FAIL b2b_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait0(lat);
    vectors++; if (lat !== 5) begin miscompares++;
      $display("FAIL b2b_second_latency: got %0d want 5", lat); end
    vectors++; if (out_vector !== eb) begin miscompares++;
      $display("FAIL b2b_second_data: got %h want %h", out_vector, eb); end
    drain0();
  endtask

  task automatic test_params();
    logic [9:0][31:0] e1;
    vec_t             e2;
    int               lat;
    int               t;
    for (int i = 0; i < 10; i++) begin
      v1_in[i] = 32'(i + 1);
      e1[i]    = 32'(8 * (i + 1));
    end
    in_shamt = 6'd3; in_mode = SHM_LSL_WRAP; in_round = 1'b0; v1_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1_in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (v1_out_valid === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    vectors++; if (lat !== 4) begin miscompares++;
      $display("FAIL n10_latency: got %0d want 4", lat); end
    vectors++; if (v1_out !== e1) begin miscompares++;
      $display("FAIL n10_data: got %h want %h", v1_out, e1); end
    v1_out_ready = 1'b1; @(posedge clk); @(negedge clk); v1_out_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v2_in[i] = 32'(-(i + 1));
      t        = -i;
      e2[i]    = 32'(t >>> 1);
    end
    in_shamt = 6'd1; in_mode = SHM_ASR; in_round = 1'b1; v2_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v2_in_valid = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (v2_out_valid === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    vectors++; if (lat !== 2) begin miscompares++;
      $display("FAIL wide_latency: got %0d want 2", lat); end
    vectors++; if (v2_out !== e2) begin miscompares++;
      $display("FAIL wide_data: got %h want %h", v2_out, e2); end
    v2_out_ready = 1'b1; @(posedge clk); @(negedge clk); v2_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    vec_t v, e;
    int   lat;
    v = '0;
    v[0] = 32'h7FFF_FFFF;
    for (int i = 1; i < 16; i++) v[i] = 32'(i + 1);
    in_vector = v; in_shamt = 6'd4; in_mode = SHM_LSL_SAT; in_round = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_ovf !== 1'b1) begin miscompares++;
      $display("FAIL mid_pre_reset_ovf: got %b want 1", out_ovf); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vector !== '0 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got rdy=%b vld=%b ovf=%b vec=%h want 1 0 0 0",
               in_ready, out_valid, out_ovf, out_vector);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++;
        $display("FAIL mid_reset_hold[%0d]: got vld=%b want 0", c, out_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      v[i] = 32'(8 * (i + 1));
      e[i] = 32'(i + 1);
    end
    send0(v, 6'd3, SHM_ASR, 1'b0, lat);
    vectors++; if (lat !== 5) begin miscompares++;
      $display("FAIL mid_after_latency: got %0d want 5", lat); end
    vectors++; if (out_vector !== e) begin miscompares++;
      $display("FAIL mid_after_data: got %h want %h", out_vector, e); end
    drain0();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_vector = '0; in_shamt = '0;
    in_mode = SHM_LSR; in_round = 1'b0;
    v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_in = '0;
    v2_in_valid = 1'b0; v2_out_ready = 1'b0; v2_in = '0;
    test_reset();
    test_asr();
    test_lsr_round();
    test_lsl();
    test_back_to_back();
    test_params();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
